// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32 pipeline: MDU scoreboard, memory wait-state freeze, 3-source forwarding.
// Optional performance counters are enabled with HAZARD_UNIT_PERF_CNT_EN.
module hazard_unit_mc #(
  parameter int NUM_REGS        = 32,
  parameter int ADDR_W          = 5,
  parameter int MDU_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] D_rs1_addr,
  input  logic [ADDR_W-1:0] D_rs2_addr,
  input  logic [ADDR_W-1:0] D_rd_addr,
  input  logic              D_gpr_wen,
  input  logic [ADDR_W-1:0] E_rs1_addr,
  input  logic [ADDR_W-1:0] E_rs2_addr,
  input  logic [ADDR_W-1:0] E_rd_addr,
  input  logic [1:0]        E_rd_src_sel,
  input  logic [1:0]        E_pc_src_sel,
  input  logic              E_mdu_start,
  input  logic [ADDR_W-1:0] M_rd_addr,
  input  logic [ADDR_W-1:0] W_rd_addr,
  input  logic              M_gpr_wen,
  input  logic              W_gpr_wen,
  input  logic              M_mem_req,
  input  logic              M_mem_ready,
  input  logic              mdu_done,
  input  logic [ADDR_W-1:0] mdu_rd_addr,
  output logic [1:0]        E_forward_src_a_sel,
  output logic [1:0]        E_forward_src_b_sel,
  output logic              F_stall_pc,
  output logic              F_stall_fetch_reg,
  output logic              F_flush_fetch_reg,
  output logic              D_stall_decode_reg,
  output logic              D_flush_decode_reg,
  output logic              E_stall_exec_reg,
  output logic              E_flush_exec_reg,
  output logic              M_stall_mem_reg,
  output logic              M_flush_mem_reg,
  output logic [CNT_W-1:0]  mdu_pending_cnt,
  output logic              sb_err
`ifdef HAZARD_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_events
`endif
);

  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MDU_OUTSTANDING);
  localparam logic [NUM_REGS-1:0] X0_BIT  = NUM_REGS'(1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_eff;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [CNT_W-1:0]    cnt;
  logic                mem_wait;
  logic                mdu_full;
  logic                load_use;
  logic                sb_hit;
  logic                ctrl;
  logic                accept;

  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] rs,
    input logic [ADDR_W-1:0] m_rd,
    input logic              m_wen,
    input logic [ADDR_W-1:0] w_rd,
    input logic              w_wen,
    input logic [ADDR_W-1:0] x_rd,
    input logic              x_done
  );
    if (rs == '0)                   return 2'b00;
    else if (m_wen && rs == m_rd)   return 2'b01;
    else if (w_wen && rs == w_rd)   return 2'b10;
    else if (x_done && rs == x_rd)  return 2'b11;
    else                            return 2'b00;
  endfunction

  assign accept   = E_mdu_start & ~mem_wait & ~mdu_full;
  assign mem_wait = M_mem_req & ~M_mem_ready;
  assign mdu_full = E_mdu_start & (cnt == CNT_MAX) & ~mdu_done;
  assign ctrl     = (E_pc_src_sel == 2'b01) | (E_pc_src_sel == 2'b10);
  assign load_use = (E_rd_src_sel == 2'b01) & (E_rd_addr != '0) &
                    ((E_rd_addr == D_rs1_addr) | (E_rd_addr == D_rs2_addr));

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mdu_done)                       clr_mask[mdu_rd_addr] = 1'b1;
    if (accept && E_rd_addr != '0)      set_mask[E_rd_addr]   = 1'b1;
  end

  // The register file is write-first, so a result landing this cycle is already readable.
  assign pending_eff = pending & ~clr_mask;
  assign sb_hit      = pending_eff[D_rs1_addr] | pending_eff[D_rs2_addr] |
                       (D_gpr_wen & pending_eff[D_rd_addr]);

  always_comb begin
    E_forward_src_a_sel = 2'b00;
    E_forward_src_b_sel = 2'b00;
    F_stall_pc          = 1'b0;
    F_stall_fetch_reg   = 1'b0;
    F_flush_fetch_reg   = 1'b0;
    D_stall_decode_reg  = 1'b0;
    D_flush_decode_reg  = 1'b0;
    E_stall_exec_reg    = 1'b0;
    E_flush_exec_reg    = 1'b0;
    M_stall_mem_reg     = 1'b0;
    M_flush_mem_reg     = 1'b0;
    if (rst_n) begin
      E_forward_src_a_sel = fwd_sel(E_rs1_addr, M_rd_addr, M_gpr_wen, W_rd_addr, W_gpr_wen,
                                    mdu_rd_addr, mdu_done);
      E_forward_src_b_sel = fwd_sel(E_rs2_addr, M_rd_addr, M_gpr_wen, W_rd_addr, W_gpr_wen,
                                    mdu_rd_addr, mdu_done);
      if (mem_wait) begin
        // Freeze the whole pipe; a resolving branch waits in E until memory releases.
        F_stall_pc         = 1'b1;
        F_stall_fetch_reg  = 1'b1;
        D_stall_decode_reg = 1'b1;
        E_stall_exec_reg   = 1'b1;
        M_stall_mem_reg    = 1'b1;
        M_flush_mem_reg    = 1'b1;
      end else if (mdu_full) begin
        F_stall_pc         = 1'b1;
        F_stall_fetch_reg  = 1'b1;
        D_stall_decode_reg = 1'b1;
        E_stall_exec_reg   = 1'b1;
        E_flush_exec_reg   = 1'b1;
      end else if (ctrl) begin
        F_flush_fetch_reg  = 1'b1;
        D_flush_decode_reg = 1'b1;
      end else if (load_use || sb_hit) begin
        F_stall_pc         = 1'b1;
        F_stall_fetch_reg  = 1'b1;
        D_flush_decode_reg = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      cnt     <= '0;
      sb_err  <= 1'b0;
    end else begin
      // Set is applied after clear, so a same-cycle set/clear on one register leaves it pending.
      pending <= (pending_eff | set_mask) & ~X0_BIT;
      case ({accept, mdu_done})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if ((mdu_done && cnt == '0) || (accept && cnt == CNT_MAX))
        sb_err <= 1'b1;
    end
  end

  assign mdu_pending_cnt = cnt;

`ifdef HAZARD_UNIT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (F_stall_pc)        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (F_flush_fetch_reg) perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: combinational vector table plus multi-cycle scoreboard,
// MDU back-pressure, memory-freeze and error-flag sequences.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_rs1_addr, D_rs2_addr, D_rd_addr;
  logic       D_gpr_wen;
  logic [4:0] E_rs1_addr, E_rs2_addr, E_rd_addr;
  logic [1:0] E_rd_src_sel, E_pc_src_sel;
  logic       E_mdu_start;
  logic [4:0] M_rd_addr, W_rd_addr;
  logic       M_gpr_wen, W_gpr_wen, M_mem_req, M_mem_ready;
  logic       mdu_done;
  logic [4:0] mdu_rd_addr;
  logic [1:0] E_forward_src_a_sel, E_forward_src_b_sel;
  logic       F_stall_pc, F_stall_fetch_reg, F_flush_fetch_reg;
  logic       D_stall_decode_reg, D_flush_decode_reg;
  logic       E_stall_exec_reg, E_flush_exec_reg;
  logic       M_stall_mem_reg, M_flush_mem_reg;
  logic [2:0] mdu_pending_cnt;
  logic       sb_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Packed view: {F_stall_pc, F_stall_fetch, F_flush_fetch, D_stall, D_flush, E_stall, E_flush, M_stall, M_flush}
  logic [8:0] ctrl_obs;
  assign ctrl_obs = {F_stall_pc, F_stall_fetch_reg, F_flush_fetch_reg, D_stall_decode_reg,
                     D_flush_decode_reg, E_stall_exec_reg, E_flush_exec_reg,
                     M_stall_mem_reg, M_flush_mem_reg};

  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_BUBBLE = 9'b110010000;
  localparam logic [8:0] C_CTRL   = 9'b001010000;
  localparam logic [8:0] C_MEM    = 9'b110101011;
  localparam logic [8:0] C_FULL   = 9'b110101100;

  hazard_unit_mc dut (
    .clk(clk), .rst_n(rst_n),
    .D_rs1_addr(D_rs1_addr), .D_rs2_addr(D_rs2_addr), .D_rd_addr(D_rd_addr), .D_gpr_wen(D_gpr_wen),
    .E_rs1_addr(E_rs1_addr), .E_rs2_addr(E_rs2_addr), .E_rd_addr(E_rd_addr),
    .E_rd_src_sel(E_rd_src_sel), .E_pc_src_sel(E_pc_src_sel), .E_mdu_start(E_mdu_start),
    .M_rd_addr(M_rd_addr), .W_rd_addr(W_rd_addr), .M_gpr_wen(M_gpr_wen), .W_gpr_wen(W_gpr_wen),
    .M_mem_req(M_mem_req), .M_mem_ready(M_mem_ready),
    .mdu_done(mdu_done), .mdu_rd_addr(mdu_rd_addr),
    .E_forward_src_a_sel(E_forward_src_a_sel), .E_forward_src_b_sel(E_forward_src_b_sel),
    .F_stall_pc(F_stall_pc), .F_stall_fetch_reg(F_stall_fetch_reg),
    .F_flush_fetch_reg(F_flush_fetch_reg),
    .D_stall_decode_reg(D_stall_decode_reg), .D_flush_decode_reg(D_flush_decode_reg),
    .E_stall_exec_reg(E_stall_exec_reg), .E_flush_exec_reg(E_flush_exec_reg),
    .M_stall_mem_reg(M_stall_mem_reg), .M_flush_mem_reg(M_flush_mem_reg),
    .mdu_pending_cnt(mdu_pending_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] e_rs1, e_rs2, e_rd, m_rd, w_rd, mdu_rd, d_rs1, d_rs2;
    logic       m_wen, w_wen, x_done, m_req, m_ready;
    logic [1:0] e_rd_src, e_pc_src;
    logic [1:0] exp_a, exp_b;
    logic [8:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    D_rs1_addr = '0; D_rs2_addr = '0; D_rd_addr = '0; D_gpr_wen = 1'b0;
    E_rs1_addr = '0; E_rs2_addr = '0; E_rd_addr = '0;
    E_rd_src_sel = 2'b00; E_pc_src_sel = 2'b00; E_mdu_start = 1'b0;
    M_rd_addr = '0; W_rd_addr = '0; M_gpr_wen = 1'b0; W_gpr_wen = 1'b0;
    M_mem_req = 1'b0; M_mem_ready = 1'b1; mdu_done = 1'b0; mdu_rd_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t blank(input string name);
    vec_t v;
    v.name = name;
    v.e_rs1 = '0; v.e_rs2 = '0; v.e_rd = '0; v.m_rd = '0; v.w_rd = '0; v.mdu_rd = '0;
    v.d_rs1 = '0; v.d_rs2 = '0;
    v.m_wen = 1'b0; v.w_wen = 1'b0; v.x_done = 1'b0; v.m_req = 1'b0; v.m_ready = 1'b1;
    v.e_rd_src = 2'b00; v.e_pc_src = 2'b00;
    v.exp_a = 2'b00; v.exp_b = 2'b00; v.exp_ctrl = C_NONE;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    idle();
    E_rs1_addr = v.e_rs1; E_rs2_addr = v.e_rs2; E_rd_addr = v.e_rd;
    M_rd_addr = v.m_rd; W_rd_addr = v.w_rd; mdu_rd_addr = v.mdu_rd;
    D_rs1_addr = v.d_rs1; D_rs2_addr = v.d_rs2;
    M_gpr_wen = v.m_wen; W_gpr_wen = v.w_wen; mdu_done = v.x_done;
    M_mem_req = v.m_req; M_mem_ready = v.m_ready;
    E_rd_src_sel = v.e_rd_src; E_pc_src_sel = v.e_pc_src;
  endtask

  initial begin
    vec_t v;
    v = blank("idle");                                                           vecs.push_back(v);
    v = blank("load_use_rs1"); v.e_rd_src = 2'b01; v.e_rd = 5; v.d_rs1 = 5;
    v.exp_ctrl = C_BUBBLE;                                                       vecs.push_back(v);
    v = blank("load_use_x0");  v.e_rd_src = 2'b01; v.e_rd = 0; v.d_rs1 = 0;      vecs.push_back(v);
    v = blank("load_use_rs2"); v.e_rd_src = 2'b01; v.e_rd = 9; v.d_rs2 = 9;
    v.exp_ctrl = C_BUBBLE;                                                       vecs.push_back(v);
    v = blank("non_load_src"); v.e_rd_src = 2'b10; v.e_rd = 5; v.d_rs1 = 5;      vecs.push_back(v);
    v = blank("branch");       v.e_pc_src = 2'b01; v.exp_ctrl = C_CTRL;          vecs.push_back(v);
    v = blank("jump_over_lu"); v.e_pc_src = 2'b10; v.e_rd_src = 2'b01; v.e_rd = 5;
    v.d_rs1 = 5; v.exp_ctrl = C_CTRL;                                            vecs.push_back(v);
    v = blank("pc_src_11");    v.e_pc_src = 2'b11;                               vecs.push_back(v);
    v = blank("mem_wait");     v.m_req = 1'b1; v.m_ready = 1'b0; v.exp_ctrl = C_MEM; vecs.push_back(v);
    v = blank("mem_wait_br");  v.m_req = 1'b1; v.m_ready = 1'b0; v.e_pc_src = 2'b01;
    v.exp_ctrl = C_MEM;                                                          vecs.push_back(v);
    v = blank("mem_ready_br"); v.m_req = 1'b1; v.m_ready = 1'b1; v.e_pc_src = 2'b01;
    v.exp_ctrl = C_CTRL;                                                         vecs.push_back(v);
    v = blank("fwd_m_over_w"); v.e_rs1 = 3; v.m_rd = 3; v.m_wen = 1'b1; v.w_rd = 3;
    v.w_wen = 1'b1; v.exp_a = 2'b01;                                             vecs.push_back(v);
    v = blank("fwd_w_over_x"); v.e_rs1 = 3; v.m_rd = 3; v.w_rd = 3; v.w_wen = 1'b1;
    v.mdu_rd = 3; v.x_done = 1'b1; v.exp_a = 2'b10;                              vecs.push_back(v);
    v = blank("fwd_mdu");      v.e_rs1 = 3; v.m_rd = 3; v.w_rd = 3; v.mdu_rd = 3;
    v.x_done = 1'b1; v.exp_a = 2'b11;                                            vecs.push_back(v);
    v = blank("fwd_x0");       v.m_wen = 1'b1; v.w_wen = 1'b1; v.x_done = 1'b1;  vecs.push_back(v);
    v = blank("fwd_split");    v.e_rs1 = 6; v.w_rd = 6; v.w_wen = 1'b1; v.e_rs2 = 7;
    v.mdu_rd = 7; v.x_done = 1'b1; v.m_rd = 8; v.m_wen = 1'b1;
    v.exp_a = 2'b10; v.exp_b = 2'b11;                                            vecs.push_back(v);

    // Outputs are forced low while reset is held.
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    E_rd_src_sel = 2'b01; E_rd_addr = 5; D_rs1_addr = 5;
    E_rs1_addr = 3; M_rd_addr = 3; M_gpr_wen = 1'b1;
    #1;
    check("rst_ctrl_forced", ctrl_obs, C_NONE);
    check("rst_fwd_forced", E_forward_src_a_sel, 2'b00);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    check("rst_cnt", mdu_pending_cnt, 0);
    check("rst_sb_err", sb_err, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check({vecs[i].name, "_a"}, E_forward_src_a_sel, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, E_forward_src_b_sel, vecs[i].exp_b);
      check({vecs[i].name, "_ctrl"}, ctrl_obs, vecs[i].exp_ctrl);
    end

    // Scoreboard: MDU op on x7, decode waits until the write-back cycle.
    do_reset();
    @(negedge clk);
    idle(); E_mdu_start = 1'b1; E_rd_addr = 7;
    #1 check("sb_issue_ctrl", ctrl_obs, C_NONE);
    @(negedge clk);
    idle(); D_rs1_addr = 7;
    #1 check("sb_cnt_1", mdu_pending_cnt, 1);
    check("sb_stall_0", ctrl_obs, C_BUBBLE);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      #1 check($sformatf("sb_stall_%0d", i), ctrl_obs, C_BUBBLE);
    end
    @(negedge clk);
    D_rs1_addr = 0; D_rd_addr = 7; D_gpr_wen = 1'b1;
    #1 check("sb_waw_stall", ctrl_obs, C_BUBBLE);
    @(negedge clk);
    D_rs1_addr = 7; D_rd_addr = 0; D_gpr_wen = 1'b0; mdu_done = 1'b1; mdu_rd_addr = 7;
    #1 check("sb_done_write_first", ctrl_obs, C_NONE);
    @(negedge clk);
    mdu_done = 1'b0;
    #1 check("sb_cnt_0", mdu_pending_cnt, 0);
    check("sb_cleared", ctrl_obs, C_NONE);

    // Back-pressure at MDU_OUTSTANDING = 2.
    @(negedge clk);
    idle(); E_mdu_start = 1'b1; E_rd_addr = 8;
    @(negedge clk);
    E_rd_addr = 9;
    #1 check("full_cnt_1", mdu_pending_cnt, 1);
    @(negedge clk);
    E_rd_addr = 10;
    #1 check("full_cnt_2", mdu_pending_cnt, 2);
    check("full_stall", ctrl_obs, C_FULL);
    @(negedge clk);
    #1 check("full_cnt_held", mdu_pending_cnt, 2);
    check("full_stall_held", ctrl_obs, C_FULL);
    @(negedge clk);
    mdu_done = 1'b1; mdu_rd_addr = 8;
    #1 check("full_done_release", ctrl_obs, C_NONE);
    @(negedge clk);
    idle(); D_rs1_addr = 10;
    #1 check("full_swap_cnt", mdu_pending_cnt, 2);
    check("full_x10_pending", ctrl_obs, C_BUBBLE);
    @(negedge clk);
    D_rs1_addr = 8;
    #1 check("full_x8_cleared", ctrl_obs, C_NONE);
    // Re-issue to x9 in the cycle x9 completes: the set must win.
    @(negedge clk);
    idle(); E_mdu_start = 1'b1; E_rd_addr = 9; mdu_done = 1'b1; mdu_rd_addr = 9;
    @(negedge clk);
    idle(); D_rs2_addr = 9;
    #1 check("set_wins_stall", ctrl_obs, C_BUBBLE);
    check("set_wins_cnt", mdu_pending_cnt, 2);

    // Memory wait freezes everything, a branch in E waits, MDU issue is held off.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); M_mem_req = 1'b1; M_mem_ready = 1'b0; E_pc_src_sel = 2'b01;
      E_mdu_start = 1'b1; E_rd_addr = 12;
      #1 check($sformatf("memwait_%0d", i), ctrl_obs, C_MEM);
    end
    @(negedge clk);
    M_mem_ready = 1'b1; E_mdu_start = 1'b0;
    #1 check("memwait_release", ctrl_obs, C_CTRL);
    check("memwait_no_accept", mdu_pending_cnt, 0);

    // Spurious completion sets a sticky error.
    @(negedge clk);
    idle();
    #1 check("err_clear_before", sb_err, 0);
    @(negedge clk);
    mdu_done = 1'b1; mdu_rd_addr = 3;
    @(negedge clk);
    idle();
    #1 check("err_set", sb_err, 1);
    check("err_cnt_floor", mdu_pending_cnt, 0);
    repeat (2) @(negedge clk);
    #1 check("err_sticky", sb_err, 1);

    // Reset drops an in-flight op; its late completion is an error.
    @(negedge clk);
    idle(); E_mdu_start = 1'b1; E_rd_addr = 11;
    @(negedge clk);
    idle(); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; D_rs1_addr = 11;
    #1 check("rst2_sb_err", sb_err, 0);
    check("rst2_cnt", mdu_pending_cnt, 0);
    check("rst2_pending", ctrl_obs, C_NONE);
    @(negedge clk);
    idle(); mdu_done = 1'b1; mdu_rd_addr = 11;
    @(negedge clk);
    idle();
    #1 check("late_done_err", sb_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
